// File: rtl/word_frame_controller_if.sv
// Bit-stream input, word output handshake and frame status for word_frame_controller.
// master drives the bit stream and word_ready; slave is the framer.
interface word_frame_controller_if #(
    parameter int WORD_W = 12
);
    logic              enable;
    logic              bit_in;
    logic              bit_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              frame_start;
    logic              frame_done;
    logic              frame_err;
    logic              overflow;
    logic [1:0]        state;

    modport master (
        output enable, bit_in, bit_valid, word_ready,
        input  word_out, word_valid, frame_start, frame_done, frame_err, overflow, state
    );

    modport slave (
        input  enable, bit_in, bit_valid, word_ready,
        output word_out, word_valid, frame_start, frame_done, frame_err, overflow, state
    );
endinterface

// File: rtl/word_frame_controller.sv
// Sync-aligned serial word framer: hunts for a sync pattern, assembles MSB-first
// words, checks the marker bit and queues good words in a 2-entry output buffer.
module word_frame_controller #(
    parameter int                WORD_W          = 12,
    parameter int                SYNC_W          = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN    = 8'hD5,
    parameter int                WORDS_PER_FRAME = 4,
    parameter int                TIMEOUT         = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    word_frame_controller_if.slave bus
);
    localparam int BCW = $clog2(WORD_W + 1);
    localparam int SCW = $clog2(SYNC_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HUNT    = 2'b01,
        COLLECT = 2'b10
    } state_e;

    state_e            state_q;
    logic [SYNC_W-1:0] sync_q;
    logic [SCW-1:0]    sync_cnt_q;
    logic [WORD_W-1:0] shift_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [3:0]        word_cnt_q;
    logic [7:0]        idle_cnt_q;
    logic              start_q, done_q, err_q;

    logic [WORD_W-1:0] head_q, tail_q;
    logic [1:0]        fifo_cnt_q;
    logic              ovf_q;

    logic [SYNC_W-1:0] sync_d;
    logic [WORD_W-1:0] shift_d;
    logic              word_end, push, pop, flush;

    assign sync_d   = {sync_q[SYNC_W-2:0], bus.bit_in};
    assign shift_d  = {shift_q[WORD_W-2:0], bus.bit_in};
    assign word_end = (state_q == COLLECT) && bus.enable && bus.bit_valid &&
                      (bit_cnt_q == BCW'(WORD_W - 1));
    // The marker is judged on the completed word, including the bit arriving now.
    assign push     = word_end && shift_d[WORD_W-1];
    assign pop      = (fifo_cnt_q != 2'd0) && bus.word_ready;
    assign flush    = !bus.enable || (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            sync_cnt_q <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (!bus.enable) begin
                state_q    <= IDLE;
                sync_q     <= '0;
                sync_cnt_q <= '0;
                shift_q    <= '0;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                idle_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= HUNT;
                        sync_q     <= '0;
                        sync_cnt_q <= '0;
                    end
                    HUNT: begin
                        if (bus.bit_valid) begin
                            sync_q <= sync_d;
                            if (sync_cnt_q != SCW'(SYNC_W)) sync_cnt_q <= sync_cnt_q + 1'b1;
                            // A full window of fresh bits is needed before a match counts.
                            if (sync_d == SYNC_PATTERN && sync_cnt_q >= SCW'(SYNC_W - 1)) begin
                                state_q    <= COLLECT;
                                start_q    <= 1'b1;
                                shift_q    <= '0;
                                bit_cnt_q  <= '0;
                                word_cnt_q <= '0;
                                idle_cnt_q <= '0;
                            end
                        end
                    end
                    COLLECT: begin
                        if (bus.bit_valid) begin
                            idle_cnt_q <= '0;
                            shift_q    <= shift_d;
                            if (bit_cnt_q == BCW'(WORD_W - 1)) begin
                                bit_cnt_q <= '0;
                                if (shift_d[WORD_W-1]) begin
                                    word_cnt_q <= word_cnt_q + 1'b1;
                                    if (word_cnt_q == 4'(WORDS_PER_FRAME - 1)) begin
                                        done_q     <= 1'b1;
                                        state_q    <= HUNT;
                                        sync_q     <= '0;
                                        sync_cnt_q <= '0;
                                    end
                                end else begin
                                    err_q      <= 1'b1;
                                    state_q    <= HUNT;
                                    sync_q     <= '0;
                                    sync_cnt_q <= '0;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else if (idle_cnt_q == 8'(TIMEOUT - 1)) begin
                            err_q      <= 1'b1;
                            state_q    <= HUNT;
                            sync_q     <= '0;
                            sync_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Two-entry buffer kept as explicit head/tail registers so word_out is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            fifo_cnt_q <= 2'd0;
            ovf_q      <= 1'b0;
        end else if (flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            fifo_cnt_q <= 2'd0;
            ovf_q      <= 1'b0;
        end else begin
            case (fifo_cnt_q)
                2'd0: begin
                    if (push) begin
                        head_q     <= shift_d;
                        fifo_cnt_q <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: head_q <= shift_d;
                        2'b10: begin
                            tail_q     <= shift_d;
                            fifo_cnt_q <= 2'd2;
                        end
                        2'b01: fifo_cnt_q <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    case ({push, pop})
                        2'b11: begin
                            head_q <= tail_q;
                            tail_q <= shift_d;
                        end
                        2'b01: begin
                            head_q     <= tail_q;
                            fifo_cnt_q <= 2'd1;
                        end
                        2'b10: ovf_q <= 1'b1;
                        default: ;
                    endcase
                end
                default: fifo_cnt_q <= 2'd0;
            endcase
        end
    end

    assign bus.word_out    = head_q;
    assign bus.word_valid  = (fifo_cnt_q != 2'd0);
    assign bus.frame_start = start_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_err   = err_q;
    assign bus.overflow    = ovf_q;
    assign bus.state       = state_q;
endmodule
